// File: rtl/bellek_hakem_pkg.sv
// Shared definitions for the main-memory arbiter: FSM states, owner
// constants and the line-offset width helper.
package bellek_hakem_pkg;

    typedef enum logic [2:0] {
        BOSTA = 3'd0,
        ADRES = 3'd1,
        OKU   = 3'd2,
        YAZ   = 3'd3,
        BITTI = 3'd4
    } durum_e;

    localparam logic SAHIP_BUYRUK = 1'b0;
    localparam logic SAHIP_VERI   = 1'b1;

    // Number of byte-offset bits inside one cache line.
    function automatic int unsigned ofset_bit(input int unsigned kelime,
                                              input int unsigned veri_bit);
        return $clog2(kelime * veri_bit / 8);
    endfunction

endpackage

// File: rtl/bellek_hakem_rr.sv
// Two-input round-robin grant. The last served owner loses a tie; the
// history register only moves when the top finishes a transaction.
module hakem_rr
    import bellek_hakem_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic istek_bb_i,
    input  logic istek_vb_i,
    input  logic guncelle_i,
    input  logic sahip_i,
    output logic verildi_o,
    output logic sahip_o
);

    logic son_sahip_q, son_sahip_d;

    // Grant decision from the current requests and the last owner.
    always_comb begin
        verildi_o = istek_bb_i | istek_vb_i;
        sahip_o   = SAHIP_BUYRUK;
        if (istek_bb_i && istek_vb_i) begin
            sahip_o = ~son_sahip_q;
        end else if (istek_vb_i) begin
            sahip_o = SAHIP_VERI;
        end
    end

    // Remember who was served last, on completion only.
    always_comb begin
        son_sahip_d = son_sahip_q;
        if (guncelle_i) begin
            son_sahip_d = sahip_i;
        end
    end

    // History register; reset favours the data side on the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) son_sahip_q <= SAHIP_BUYRUK;
        else       son_sahip_q <= son_sahip_d;
    end

endmodule

// File: rtl/bellek_hakem.sv
// Arbitrates instruction-side and data-side line transactions onto the
// single main-memory port: grant, address phase, data beats, completion.
module bellek_hakem
    import bellek_hakem_pkg::*;
#(
    parameter int ADRES_BIT    = 32,
    parameter int VERI_BIT     = 32,
    parameter int SATIR_KELIME = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bb_istek_i,
    input  logic [ADRES_BIT-1:0] bb_adres_i,
    output logic [VERI_BIT-1:0]  bb_veri_o,
    output logic                 bb_veri_gecerli_o,
    output logic                 bb_bitti_o,
    input  logic                 vb_istek_i,
    input  logic                 vb_yaz_i,
    input  logic [ADRES_BIT-1:0] vb_adres_i,
    input  logic [VERI_BIT-1:0]  vb_yaz_veri_i,
    output logic                 vb_yaz_veri_al_o,
    output logic [VERI_BIT-1:0]  vb_veri_o,
    output logic                 vb_veri_gecerli_o,
    output logic                 vb_bitti_o,
    output logic                 ab_istek_o,
    output logic                 ab_yaz_o,
    output logic [ADRES_BIT-1:0] ab_adres_o,
    input  logic                 ab_hazir_i,
    input  logic [VERI_BIT-1:0]  ab_oku_veri_i,
    input  logic                 ab_oku_gecerli_i,
    output logic [VERI_BIT-1:0]  ab_yaz_veri_o,
    output logic                 ab_yaz_gecerli_o,
    input  logic                 ab_yaz_hazir_i
);

    localparam int                   OFS       = ofset_bit(SATIR_KELIME, VERI_BIT);
    localparam logic [ADRES_BIT-1:0] HIZA_MASK = {ADRES_BIT{1'b1}} << OFS;
    localparam int                   SAY_BIT   = $clog2(SATIR_KELIME);
    localparam logic [SAY_BIT-1:0]   SON       = SAY_BIT'(SATIR_KELIME - 1);

    durum_e                 durum_q, durum_d;
    logic [SAY_BIT-1:0]     sayac_q, sayac_d;
    logic                   sahip_q, sahip_d;
    logic                   yaz_q, yaz_d;
    logic [ADRES_BIT-1:0]   adres_q, adres_d;
    logic                   rr_verildi, rr_sahip;

    hakem_rr u_rr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .istek_bb_i (bb_istek_i),
        .istek_vb_i (vb_istek_i),
        .guncelle_i (durum_q == BITTI),
        .sahip_i    (sahip_q),
        .verildi_o  (rr_verildi),
        .sahip_o    (rr_sahip)
    );

    // Next state: requests are only looked at in BOSTA; everything the
    // transaction needs is latched at grant so later input changes are moot.
    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q;
        sahip_d = sahip_q;
        yaz_d   = yaz_q;
        adres_d = adres_q;
        case (durum_q)
            BOSTA: begin
                if (rr_verildi) begin
                    sahip_d = rr_sahip;
                    yaz_d   = (rr_sahip == SAHIP_VERI) ? vb_yaz_i : 1'b0;
                    adres_d = ((rr_sahip == SAHIP_VERI) ? vb_adres_i : bb_adres_i) & HIZA_MASK;
                    durum_d = ADRES;
                end
            end
            ADRES: begin
                if (ab_hazir_i) begin
                    sayac_d = '0;
                    durum_d = yaz_q ? YAZ : OKU;
                end
            end
            OKU: begin
                if (ab_oku_gecerli_i) begin
                    if (sayac_q == SON) begin
                        sayac_d = '0;
                        durum_d = BITTI;
                    end else begin
                        sayac_d = sayac_q + SAY_BIT'(1);
                    end
                end
            end
            YAZ: begin
                if (ab_yaz_hazir_i) begin
                    if (sayac_q == SON) begin
                        sayac_d = '0;
                        durum_d = BITTI;
                    end else begin
                        sayac_d = sayac_q + SAY_BIT'(1);
                    end
                end
            end
            BITTI:   durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q <= BOSTA;
            sayac_q <= '0;
            sahip_q <= SAHIP_BUYRUK;
            yaz_q   <= 1'b0;
            adres_q <= '0;
        end else begin
            durum_q <= durum_d;
            sayac_q <= sayac_d;
            sahip_q <= sahip_d;
            yaz_q   <= yaz_d;
            adres_q <= adres_d;
        end
    end

    // Output muxing by state; held quiet while reset is asserted.
    always_comb begin
        bb_veri_o         = '0;
        bb_veri_gecerli_o = 1'b0;
        bb_bitti_o        = 1'b0;
        vb_veri_o         = '0;
        vb_veri_gecerli_o = 1'b0;
        vb_bitti_o        = 1'b0;
        vb_yaz_veri_al_o  = 1'b0;
        ab_istek_o        = 1'b0;
        ab_yaz_o          = 1'b0;
        ab_adres_o        = '0;
        ab_yaz_veri_o     = '0;
        ab_yaz_gecerli_o  = 1'b0;
        if (!rst_i) begin
            case (durum_q)
                ADRES: begin
                    ab_istek_o = 1'b1;
                    ab_yaz_o   = yaz_q;
                    ab_adres_o = adres_q;
                end
                OKU: begin
                    if (sahip_q == SAHIP_VERI) begin
                        vb_veri_o         = ab_oku_veri_i;
                        vb_veri_gecerli_o = ab_oku_gecerli_i;
                    end else begin
                        bb_veri_o         = ab_oku_veri_i;
                        bb_veri_gecerli_o = ab_oku_gecerli_i;
                    end
                end
                YAZ: begin
                    ab_yaz_gecerli_o = 1'b1;
                    ab_yaz_veri_o    = vb_yaz_veri_i;
                    vb_yaz_veri_al_o = ab_yaz_hazir_i;
                end
                BITTI: begin
                    if (sahip_q == SAHIP_VERI) vb_bitti_o = 1'b1;
                    else                       bb_bitti_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
